// File: rtl/clock_div_pkg.sv
// Shared types for the fractional clock divider: FSM states, the ratio
// record held in the shadow/active registers, and the sanitising helpers
// applied whenever a ratio is loaded into the active registers.
package clock_div_pkg;

    // Widest supported mfi/mfn/mfd.  Channels zero-extend their ratio
    // inputs into this width so one record type serves every WIDTH.
    localparam int DIV_WMAX = 16;

    typedef logic [DIV_WMAX-1:0] div_word_t;
    // One extra bit: period lengths go up to mfi + 1 and s = acc + mfn
    // needs the carry bit.
    typedef logic [DIV_WMAX:0]   div_len_t;

    localparam div_len_t DIV_LEN_ONE = div_len_t'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } div_state_e;

    typedef struct packed {
        div_word_t mfi;
        div_word_t mfn;
        div_word_t mfd;
    } div_cfg_t;

    localparam div_cfg_t DIV_CFG_RESET = '{
        mfi: div_word_t'(1),
        mfn: div_word_t'(0),
        mfd: div_word_t'(1)
    };

    // True when the requested ratio cannot be used as given.
    function automatic logic cfg_invalid(input div_cfg_t c);
        return (c.mfi == '0) || (c.mfd == '0) || (c.mfn >= c.mfd);
    endfunction

    // mfi==0 runs as 1; a zero denominator or an improper fraction drops
    // the fraction.  A zero denominator is also replaced by 1 so the
    // accumulator compare (s >= mfd) never produces a spurious carry.
    function automatic div_cfg_t cfg_sanitise(input div_cfg_t c);
        div_cfg_t r;
        r = c;
        if (c.mfi == '0) begin
            r.mfi = div_word_t'(1);
        end
        if ((c.mfd == '0) || (c.mfn >= c.mfd)) begin
            r.mfn = '0;
        end
        if (c.mfd == '0) begin
            r.mfd = div_word_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_frac_div_channel.sv
// One fractional divider channel: run/stop FSM, shadow and active ratio
// registers, phase accumulator and period counter.
//
// Handshakes: enable is a level request answered by enable_ack while the
// channel is running (RUN or STOP).  update is 4-phase: a rising update
// seen while update_ack is low and nothing is pending captures the ratio
// inputs; update_ack rises once that ratio is active and falls the cycle
// after update is seen low.  Ratio inputs are ignored outside a capture.
module clock_frac_div_channel
    import clock_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             update,
    input  logic [WIDTH-1:0] mfi,
    input  logic [WIDTH-1:0] mfn,
    input  logic [WIDTH-1:0] mfd,
    output logic             enable_ack,
    output logic             update_ack,
    output logic             div_tick,
    output logic             cfg_err
);

    div_state_e state_q, state_d;
    div_len_t   cnt_q, cnt_d;
    div_len_t   len_q, len_d;
    div_word_t  acc_q, acc_d;
    div_cfg_t   act_q, act_d;
    div_cfg_t   shd_q, shd_d;
    logic       pend_q, pend_d;
    logic       uack_q, uack_d;
    logic       err_q, err_d;

    div_cfg_t   cfg_in;
    div_len_t   sum;
    div_len_t   diff;
    div_len_t   len_cur;
    logic       carry;
    logic       tick;
    logic       cap;

    assign cfg_in = '{
        mfi: div_word_t'(mfi),
        mfn: div_word_t'(mfn),
        mfd: div_word_t'(mfd)
    };

    // Next-state logic: period length at cnt==0, tick, FSM and handshakes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        acc_d   = acc_q;
        act_d   = act_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        uack_d  = uack_q;
        err_d   = err_q;

        // Length of the period is decided on its first cycle and held in
        // len_q afterwards; with len==1 the first cycle is also the tick.
        sum     = div_len_t'(acc_q) + div_len_t'(act_q.mfn);
        diff    = sum - div_len_t'(act_q.mfd);
        carry   = (sum >= div_len_t'(act_q.mfd));
        len_cur = (cnt_q == '0) ? (div_len_t'(act_q.mfi) + div_len_t'(carry)) : len_q;
        tick    = (state_q != IDLE) && (cnt_q == (len_cur - DIV_LEN_ONE));
        cap     = update && !uack_q && !pend_q;

        if (cap) begin
            shd_d = cfg_in;
        end
        if (uack_q && !update) begin
            uack_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    // A capture in this same cycle starts RUN on the new ratio.
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    act_d   = cfg_sanitise(cap ? cfg_in : shd_q);
                    err_d   = cfg_invalid(cap ? cfg_in : shd_q);
                    if (cap || pend_q) begin
                        pend_d = 1'b0;
                        uack_d = 1'b1;
                    end
                end else if (pend_q) begin
                    act_d  = cfg_sanitise(shd_q);
                    err_d  = cfg_invalid(shd_q);
                    acc_d  = '0;
                    pend_d = 1'b0;
                    uack_d = 1'b1;
                end else if (cap) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                // RUN and STOP count identically; STOP only records that
                // the channel ends at the boundary unless enable returns.
                if (cnt_q == '0) begin
                    len_d = len_cur;
                    acc_d = carry ? diff[DIV_WMAX-1:0] : sum[DIV_WMAX-1:0];
                end
                if (tick) begin
                    cnt_d   = '0;
                    state_d = enable ? RUN : IDLE;
                    if (pend_q) begin
                        act_d  = cfg_sanitise(shd_q);
                        err_d  = cfg_invalid(shd_q);
                        acc_d  = '0;
                        pend_d = 1'b0;
                        uack_d = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + DIV_LEN_ONE;
                    state_d = enable ? RUN : STOP;
                end
                if (cap) begin
                    pend_d = 1'b1;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            act_q   <= DIV_CFG_RESET;
            shd_q   <= DIV_CFG_RESET;
            pend_q  <= 1'b0;
            uack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            uack_q  <= uack_d;
            err_q   <= err_d;
        end
    end

    assign enable_ack = (state_q != IDLE);
    assign update_ack = uack_q;
    assign cfg_err    = err_q;
    // The tick is combinational from state, so it is masked while reset
    // is asserted to keep the reset cycle quiet.
    assign div_tick   = tick && !reset;

endmodule

// File: rtl/clock_frac_div_multi.sv
// Multi-channel fractional clock divider: CHANNELS independent copies of
// clock_frac_div_channel, each emitting a one-cycle tick per output period
// of MFI + MFN/MFD clock cycles.
module clock_frac_div_multi #(
    parameter int CHANNELS = 4,  // 1..16
    parameter int WIDTH    = 8   // 4..16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            enable,
    output logic [CHANNELS-1:0]            enable_ack,
    input  logic [CHANNELS-1:0]            update,
    output logic [CHANNELS-1:0]            update_ack,
    input  logic [CHANNELS-1:0][WIDTH-1:0] mfi,
    input  logic [CHANNELS-1:0][WIDTH-1:0] mfn,
    input  logic [CHANNELS-1:0][WIDTH-1:0] mfd,
    output logic [CHANNELS-1:0]            div_tick,
    output logic [CHANNELS-1:0]            cfg_err
);

    // One independent divider per channel; no shared state.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clock_frac_div_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable[g]),
            .update     (update[g]),
            .mfi        (mfi[g]),
            .mfn        (mfn[g]),
            .mfd        (mfd[g]),
            .enable_ack (enable_ack[g]),
            .update_ack (update_ack[g]),
            .div_tick   (div_tick[g]),
            .cfg_err    (cfg_err[g])
        );
    end

endmodule

// File: tb/tb_clock_frac_div_multi.sv
// Bench for clock_frac_div_multi: directed scenarios followed by random
// enable/update/reset traffic, every cycle compared against a behavioural
// model whose period lengths come from floor((k+1)*n/d) - floor(k*n/d).
module tb_clock_frac_div_multi;

    localparam int CH = 4;
    localparam int W  = 8;

    logic                   clock;
    logic                   reset;
    logic [CH-1:0]          enable;
    logic [CH-1:0]          enable_ack;
    logic [CH-1:0]          update;
    logic [CH-1:0]          update_ack;
    logic [CH-1:0][W-1:0]   mfi;
    logic [CH-1:0][W-1:0]   mfn;
    logic [CH-1:0][W-1:0]   mfd;
    logic [CH-1:0]          div_tick;
    logic [CH-1:0]          cfg_err;

    clock_frac_div_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .enable_ack (enable_ack),
        .update     (update),
        .update_ack (update_ack),
        .mfi        (mfi),
        .mfn        (mfn),
        .mfd        (mfd),
        .div_tick   (div_tick),
        .cfg_err    (cfg_err)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Scoreboard counters.
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state per channel.
    bit m_on[CH];
    bit m_pend[CH];
    bit m_ack[CH];
    bit m_err[CH];
    int m_pos[CH];
    int m_len[CH];
    int m_k[CH];
    int a_i[CH], a_n[CH], a_d[CH];
    int s_i[CH], s_n[CH], s_d[CH];
    int cur_len[CH];

    // Tick statistics from the DUT.
    int      cyc = 0;
    int      tick_cnt[CH];
    int      last_tick_cyc[CH];
    int      last_period[CH];
    logic [CH-1:0] last_tick;

    function automatic int carry_of(input int k, input int n, input int d);
        longint kk;
        kk = k;
        return int'(((kk + 1) * n) / d - (kk * n) / d);
    endfunction

    task automatic model_reset(input int c);
        m_on[c] = 0; m_pend[c] = 0; m_ack[c] = 0; m_err[c] = 0;
        m_pos[c] = 0; m_len[c] = 0; m_k[c] = 0;
        a_i[c] = 1; a_n[c] = 0; a_d[c] = 1;
        s_i[c] = 1; s_n[c] = 0; s_d[c] = 1;
    endtask

    task automatic load_shadow(input int c);
        s_i[c] = int'(mfi[c]);
        s_n[c] = int'(mfn[c]);
        s_d[c] = int'(mfd[c]);
    endtask

    task automatic load_active(input int c);
        a_i[c]   = (s_i[c] == 0) ? 1 : s_i[c];
        a_n[c]   = (s_d[c] == 0 || s_n[c] >= s_d[c]) ? 0 : s_n[c];
        a_d[c]   = (s_d[c] == 0) ? 1 : s_d[c];
        m_err[c] = (s_i[c] == 0) || (s_d[c] == 0) || (s_n[c] >= s_d[c]);
        m_k[c]   = 0;
    endtask

    task automatic model_step(input logic [CH-1:0] raw_tick);
        for (int c = 0; c < CH; c++) begin
            if (reset) begin
                model_reset(c);
            end else begin
                bit cap;
                cap = update[c] && !m_ack[c] && !m_pend[c];
                if (m_ack[c] && !update[c]) m_ack[c] = 0;
                if (!m_on[c]) begin
                    if (enable[c]) begin
                        if (cap) load_shadow(c);
                        load_active(c);
                        m_on[c]  = 1;
                        m_pos[c] = 0;
                        if (cap || m_pend[c]) begin
                            m_pend[c] = 0;
                            m_ack[c]  = 1;
                        end
                    end else if (m_pend[c]) begin
                        load_active(c);
                        m_pend[c] = 0;
                        m_ack[c]  = 1;
                    end else if (cap) begin
                        load_shadow(c);
                        m_pend[c] = 1;
                    end
                end else begin
                    if (m_pos[c] == 0) m_len[c] = cur_len[c];
                    if (raw_tick[c]) begin
                        m_pos[c] = 0;
                        m_k[c]++;
                        if (m_pend[c]) begin
                            load_active(c);
                            m_pend[c] = 0;
                            m_ack[c]  = 1;
                        end
                        m_on[c] = enable[c];
                    end else begin
                        m_pos[c]++;
                    end
                    if (cap) begin
                        load_shadow(c);
                        m_pend[c] = 1;
                    end
                end
            end
        end
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic step();
        logic [CH-1:0] raw, e_tick, e_eack, e_uack, e_err;
        #1;
        for (int c = 0; c < CH; c++) begin
            cur_len[c] = (m_pos[c] == 0) ? a_i[c] + carry_of(m_k[c], a_n[c], a_d[c]) : m_len[c];
            raw[c]     = m_on[c] && (m_pos[c] == cur_len[c] - 1);
            e_tick[c]  = raw[c] && !reset;
            e_eack[c]  = m_on[c];
            e_uack[c]  = m_ack[c];
            e_err[c]   = m_err[c];
        end
        check("div_tick",   32'(div_tick),   32'(e_tick));
        check("enable_ack", 32'(enable_ack), 32'(e_eack));
        check("update_ack", 32'(update_ack), 32'(e_uack));
        check("cfg_err",    32'(cfg_err),    32'(e_err));
        last_tick = div_tick;
        for (int c = 0; c < CH; c++) begin
            if (div_tick[c] === 1'b1) begin
                tick_cnt[c]++;
                last_period[c]   = cyc - last_tick_cyc[c];
                last_tick_cyc[c] = cyc;
            end
        end
        cyc++;
        model_step(raw);
        @(negedge clock);
    endtask

    // Step until channel c ticks; n counts the cycles stepped, tick included.
    task automatic wait_tick(input int c, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (last_tick[c] !== 1'b1 && n < 300);
        if (last_tick[c] !== 1'b1) check("wait_tick_timeout", 32'(n), 32'(0));
    endtask

    task automatic set_cfg(input int c, input int i, input int n, input int d);
        mfi[c] = W'(i);
        mfn[c] = W'(n);
        mfd[c] = W'(d);
    endtask

    int n;

    // Stimulus: directed scenarios, then random traffic, then the report.
    initial begin
        reset  = 1'b1;
        enable = '0;
        update = '0;
        mfi    = '0;
        mfn    = '0;
        mfd    = '0;
        for (int c = 0; c < CH; c++) begin
            model_reset(c);
            tick_cnt[c] = 0;
            last_tick_cyc[c] = 0;
            last_period[c] = 0;
        end
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        repeat (3) step();

        // /4 integer ratio.
        set_cfg(0, 4, 0, 1);
        update[0] = 1'b1;
        enable[0] = 1'b1;
        step();
        update[0] = 1'b0;
        check("A_enable_ack", 32'(enable_ack[0]), 32'(1));
        tick_cnt[0] = 0;
        repeat (100) step();
        check("A_ticks_in_100", 32'(tick_cnt[0]), 32'(25));

        // 2 + 1/3: periods 2,2,3.
        set_cfg(1, 2, 1, 3);
        update[1] = 1'b1;
        enable[1] = 1'b1;
        step();
        update[1] = 1'b0;
        tick_cnt[1] = 0;
        repeat (70) step();
        check("B_ticks_in_70", 32'(tick_cnt[1]), 32'(30));

        // Update to /3 at cnt=1 of a /4 period.
        wait_tick(0, n);
        step();
        set_cfg(0, 3, 0, 1);
        update[0] = 1'b1;
        wait_tick(0, n);
        check("C_old_period", 32'(last_period[0]), 32'(4));
        check("C_update_ack", 32'(update_ack[0]), 32'(1));
        update[0] = 1'b0;
        wait_tick(0, n);
        check("C_new_period", 32'(last_period[0]), 32'(3));

        // Enable dropped at cnt=1 of a /6 period.
        set_cfg(2, 6, 0, 1);
        update[2] = 1'b1;
        enable[2] = 1'b1;
        step();
        update[2] = 1'b0;
        wait_tick(2, n);
        step();
        enable[2] = 1'b0;
        wait_tick(2, n);
        check("D_last_period", 32'(last_period[2]), 32'(6));
        check("D_enable_ack_low", 32'(enable_ack[2]), 32'(0));
        tick_cnt[2] = 0;
        repeat (20) step();
        check("D_no_more_ticks", 32'(tick_cnt[2]), 32'(0));

        // Invalid ratio: mfi=0, mfn>=mfd.
        set_cfg(3, 0, 5, 3);
        update[3] = 1'b1;
        enable[3] = 1'b1;
        step();
        update[3] = 1'b0;
        check("E_cfg_err", 32'(cfg_err[3]), 32'(1));
        tick_cnt[3] = 0;
        repeat (10) step();
        check("E_ticks_every_cycle", 32'(tick_cnt[3]), 32'(10));

        // Mid-period reset, then restart ch1 at /5.
        enable = '0;
        repeat (20) step();
        enable[0] = 1'b1;
        set_cfg(1, 5, 0, 1);
        update[1] = 1'b1;
        enable[1] = 1'b1;
        step();
        update[1] = 1'b0;
        step();
        step();
        reset  = 1'b1;
        enable = '0;
        step();
        reset  = 1'b0;
        check("F_enable_ack_rst", 32'(enable_ack), 32'(0));
        check("F_update_ack_rst", 32'(update_ack), 32'(0));
        check("F_cfg_err_rst",    32'(cfg_err),    32'(0));
        set_cfg(1, 5, 0, 1);
        update[1] = 1'b1;
        enable[1] = 1'b1;
        step();
        update[1] = 1'b0;
        check("F_enable_ack", 32'(enable_ack[1]), 32'(1));
        wait_tick(1, n);
        check("F_first_tick_cycle", 32'(n), 32'(5));

        // Random traffic.
        for (int cy = 0; cy < 3000; cy++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < CH; c++) begin
                mfi[c] = W'($urandom_range(0, 7));
                mfn[c] = W'($urandom_range(0, 7));
                mfd[c] = W'($urandom_range(0, 7));
                if ($urandom_range(0, 39) == 0) enable[c] = ~enable[c];
                if (!update[c] && !m_ack[c] && $urandom_range(0, 7) == 0) update[c] = 1'b1;
                else if (update[c] && m_ack[c] && $urandom_range(0, 1) == 0) update[c] = 1'b0;
                else if (update[c] && m_pend[c] && $urandom_range(0, 15) == 0) update[c] = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
